mem_wait_unit: RTL

- Sits between the fetch and memory stages and the instruction/data buses.
- Drives the ibus/dbus valid/data_ok handshakes and holds each request stable until it completes.
- Buffers returned data while the pipeline is stalled.
- Produces the `invalid` stall request consumed by the hazard control unit, which turns it into stallpc/stallF..stallM.

---
 rtl/mem_wait_unit_pkg.sv | 44 ++++
 rtl/mem_wait_chan.sv | 90 +++++++++
 rtl/mem_wait_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_wait_unit_pkg.sv
// Shared types for the memory wait unit.
// - chan_state_t : per-channel handshake FSM state
// - ibus/dbus request and response structs describing the bus layout at default widths
// - chan_active  : true while a channel may still be issuing/awaiting its request
package mem_wait_unit_pkg;

   localparam int unsigned DefXlen = 64;
   localparam int unsigned DefIlen = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StHold  = 2'd2,
      StDrain = 2'd3
   } chan_state_t;

   typedef struct packed {
      logic               valid;
      logic [DefXlen-1:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic               data_ok;
      logic [DefIlen-1:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic               valid;
      logic [DefXlen-1:0] addr;
      logic [DefXlen-1:0] wdata;
      logic [7:0]         strobe;
      logic [2:0]         size;
   } dbus_req_t;

   typedef struct packed {
      logic               data_ok;
      logic [DefXlen-1:0] data;
   } dbus_resp_t;

   function automatic logic chan_active(chan_state_t s);
      return (s == StIdle) || (s == StWait);
   endfunction

endpackage

// File: rtl/mem_wait_chan.sv
// One bus channel: handshake FSM plus response buffer.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   need              stage wants an access this cycle
//   kill              abandon the current access (only honoured when HasDrain)
//   advance           pipeline moves this cycle
//   data_ok, bus_data bus response
//   bus_valid         bus request valid
//   done              access complete this cycle (response or buffered)
//   drain             waiting to swallow a killed response
//   data              response to the stage: live bus data or the buffer
module mem_wait_chan
   import mem_wait_unit_pkg::*;
#(
   parameter int unsigned DataW    = 32,
   parameter bit          HasDrain = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             need,
   input  logic             kill,
   input  logic             advance,
   input  logic             data_ok,
   input  logic [DataW-1:0] bus_data,
   output logic             bus_valid,
   output logic             done,
   output logic             drain,
   output logic [DataW-1:0] data
);

   chan_state_t      state_q;
   logic [DataW-1:0] buf_q;
   logic             active;
   logic             kill_en;

   assign active    = chan_active(state_q);
   assign kill_en   = HasDrain && kill;
   assign drain     = (state_q == StDrain);
   // A drained request must stay on the bus until its response arrives.
   assign bus_valid = (need && active) || drain;
   assign done      = (data_ok && active) || (state_q == StHold);
   assign data      = data_ok ? bus_data : buf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         buf_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle, StWait: begin
               if (data_ok) begin
                  if (kill_en || advance) begin
                     state_q <= StIdle;
                  end else begin
                     state_q <= StHold;
                     buf_q   <= bus_data;
                  end
               end else if (kill_en && (state_q == StWait)) begin
                  state_q <= StDrain;
               end else if (need) begin
                  state_q <= StWait;
               end else begin
                  state_q <= StIdle;
               end
            end
            StHold: begin
               if (advance || kill_en) begin
                  state_q <= StIdle;
               end
            end
            StDrain: begin
               if (data_ok) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifndef SYNTHESIS
   // The stage is stalled while a request is outstanding, so need cannot fall.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == StWait)) begin
         assert (need);
      end
   end
`endif

endmodule

// File: rtl/mem_wait_unit.sv
// Bus handshake and stall generation between fetch/memory stages and the ibus/dbus.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   i_need, i_addr, i_kill              fetch request and redirect-kill
//   d_need, d_addr, d_wdata,
//   d_strobe, d_size                    memory-stage request (strobe 0 = load)
//   advance                             pipeline moves this cycle
//   ibus_*                              instruction bus request/response
//   dbus_*                              data bus request/response
//   i_inst, d_rdata                     responses delivered to the stages
//   invalid                             stall request to hazard control
module mem_wait_unit
   import mem_wait_unit_pkg::*;
#(
   parameter int unsigned XLEN = DefXlen,
   parameter int unsigned ILEN = DefIlen
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_need,
   input  logic [XLEN-1:0] i_addr,
   input  logic            i_kill,
   input  logic            d_need,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [7:0]      d_strobe,
   input  logic [2:0]      d_size,
   input  logic            advance,
   output logic            ibus_valid,
   output logic [XLEN-1:0] ibus_addr,
   input  logic            ibus_data_ok,
   input  logic [ILEN-1:0] ibus_data,
   output logic            dbus_valid,
   output logic [XLEN-1:0] dbus_addr,
   output logic [XLEN-1:0] dbus_wdata,
   output logic [7:0]      dbus_strobe,
   output logic [2:0]      dbus_size,
   input  logic            dbus_data_ok,
   input  logic [XLEN-1:0] dbus_data,
   output logic [ILEN-1:0] i_inst,
   output logic [XLEN-1:0] d_rdata,
   output logic            invalid
);

   logic            i_done;
   logic            i_drain;
   logic            d_done;
   logic            d_drain;
   logic [XLEN-1:0] kill_addr_q;

   mem_wait_chan #(
      .DataW    (ILEN),
      .HasDrain (1'b1)
   ) u_i_chan (
      .clk       (clk),
      .reset     (reset),
      .need      (i_need),
      .kill      (i_kill),
      .advance   (advance),
      .data_ok   (ibus_data_ok),
      .bus_data  (ibus_data),
      .bus_valid (ibus_valid),
      .done      (i_done),
      .drain     (i_drain),
      .data      (i_inst)
   );

   mem_wait_chan #(
      .DataW    (XLEN),
      .HasDrain (1'b0)
   ) u_d_chan (
      .clk       (clk),
      .reset     (reset),
      .need      (d_need),
      .kill      (1'b0),
      .advance   (advance),
      .data_ok   (dbus_data_ok),
      .bus_data  (dbus_data),
      .bus_valid (dbus_valid),
      .done      (d_done),
      .drain     (d_drain),
      .data      (d_rdata)
   );

   // The fetch PC is redirected on a kill, but the abandoned request must stay on the
   // bus unchanged until its response is swallowed, so remember its address.
   always_ff @(posedge clk) begin
      if (reset) begin
         kill_addr_q <= '0;
      end else if (i_kill && !i_drain) begin
         kill_addr_q <= i_addr;
      end
   end

   assign ibus_addr   = i_drain ? kill_addr_q : i_addr;
   assign dbus_addr   = d_addr;
   assign dbus_wdata  = d_wdata;
   assign dbus_strobe = d_strobe;
   assign dbus_size   = d_size;

   // d_drain is always low (no drain on the data side); kept for symmetry.
   assign invalid = (i_need && !i_done) || (d_need && !d_done) || i_drain || d_drain;

endmodule
